pbuf2ddr: RTL and testbench
===========================

# pbuf2ddr

Streams accumulated results out of the four PE partial-sum buffer banks (pbuf) into a DDR write stream. It is the read-side counterpart of the DDR-to-PE loader. It scans the enabled banks, packs DATA_W*BATCH-bit buffer words into DDR_W-bit beats, and presents them on a valid/ready interface with full backpressure. It sits between the PE array's pbuf read ports and the DDR write channel, and is started once per output tile by the layer controller.

## Interface
- BUF_DEPTH, 256: entries per pbuf bank.
- DDR_W, DATA_W, BATCH: taken from GLOBAL_PARAM; word width W = DATA_W*BATCH; WPB = DDR_W/W words per beat. WPB must be a power of two ≥1, and elaboration fails otherwise.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; samples pix_num and bank_mask
- pix_num  input  bw(BUF_DEPTH+1)  entries to read per enabled bank (0..BUF_DEPTH)
- bank_mask  input  4  bank b is transferred when bit b = 1
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last beat handshakes
- pbuf_rd_addr  output  [3:0][bw(BUF_DEPTH)]  per-bank read address
- pbuf_rd_en  output  4  per-bank read enable; at most one bit set
- pbuf_rd_data  input  [3:0][W]  read data, valid 1 cycle after rd_en
- ddr_data  output  DDR_W  packed beat
- ddr_valid  output  1  beat valid
- ddr_ready  input  1  DDR side accepts beat when valid&&ready

## Operation
- States: IDLE → READ → DRAIN → IDLE.
- IDLE: start accepted only here. A start while busy is ignored.
- Degenerate start: if pix_num==0 or bank_mask==0, the block goes directly to a done pulse on cycle T+1, emits no beats, and busy stays low.
- READ: banks are visited in ascending index, skipping masked banks. Within a bank, addresses run 0..pix_num-1, one per cycle while credit allows.
- Packing: word i of a beat occupies bits [i*W +: W], with the first-read word in the LSBs. A beat completes after WPB words or at a bank's last word.
- Beats never straddle banks. A partial final beat is zero-padded in its upper words.
- Beats per bank = ceil(pix_num/WPB).
- Output FIFO: 4 beats deep.
- Credit rule: a read is issued only if (FIFO occupancy + beats in flight, including the beat being packed) < 4. The FIFO therefore never overflows and no read data is dropped.
- DRAIN: entered after the last read is issued. Leaves to IDLE with done=1 in the cycle after the final beat handshakes.
- ddr_data/ddr_valid: ddr_data is held stable while ddr_valid=1 and ddr_ready=0. ddr_valid never drops without a handshake.
- Reset mid-transfer: the FIFO is flushed, the state returns to IDLE, and no done pulse is produced. The partial transfer is lost.

## Timing
- Reset values:
  - busy=0, done=0, ddr_valid=0, ddr_data=0
  - pbuf_rd_en=0, pbuf_rd_addr=0
  - FIFO empty, state IDLE
- Start sampled at edge T: busy=1 and the first pbuf_rd_en are asserted at T+1, and read data arrives at T+2.
- Beat latency:
  - WPB=1 with ddr_ready held high: first ddr_valid at T+3.
  - In general: ddr_valid is asserted the cycle after the beat's last word is captured.
- Throughput: one word read per cycle and one beat per WPB cycles when ddr_ready=1 continuously. There are no bubbles between banks.
- Backpressure: reads stall within 1 cycle of the credit limit. They resume the cycle after a handshake frees a slot.
- done: asserted 1 cycle after the final handshake. busy falls in the same cycle done is high.

## Configuration
- PBUF2DDR_RELU_EN defined: each DATA_W lane is treated as signed, and negative values are replaced by 0 before packing. Registered in the packing stage, so latency is unchanged.
- PBUF2DDR_RELU_EN undefined: words are passed bit-exact.

## Test plan
1. WPB=1, pix_num=8, bank_mask=4'b0001, ddr_ready=1 → 8 beats equal to bank0[0..7], first ddr_valid at T+3, done at T+11.
2. WPB=2, pix_num=5, bank_mask=4'b1010 → 3 beats from bank1 then 3 from bank3; the third beat of each bank has its upper word = 0. done pulses once.
3. Random ddr_ready (50%), pix_num=BUF_DEPTH, all banks → 4*BUF_DEPTH/WPB beats in order with no loss or duplication, ddr_data stable while stalled, FIFO never exceeds 4.
4. pix_num=0 or bank_mask=0 → done at T+1, no rd_en, no ddr_valid.
5. Reset asserted mid-stream with ddr_ready=0 → all outputs return to reset values immediately with no done; a new start then completes normally.
6. PBUF2DDR_RELU_EN defined with lane value -3 → output lane 0. Undefined → the lane passes through raw.

Source files
------------

// File: rtl/pbuf2ddr.sv
// pbuf2ddr: drains the enabled pbuf banks into packed, credit-limited DDR write beats.
// Define PBUF2DDR_RELU_EN to clamp negative DATA_W lanes to zero while packing.
module pbuf2ddr #(
    parameter int BUF_DEPTH = 256,
    parameter int DATA_W    = 16,
    parameter int BATCH     = 2,
    parameter int DDR_W     = 64,
    localparam int W   = DATA_W * BATCH,
    localparam int WPB = DDR_W / W,
    localparam int PW  = $clog2(BUF_DEPTH + 1),
    localparam int AW  = $clog2(BUF_DEPTH),
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [PW-1:0]      pix_num_i,
    input  logic [3:0]         bank_mask_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0][AW-1:0] pbuf_rd_addr_o,
    output logic [3:0]         pbuf_rd_en_o,
    input  logic [3:0][W-1:0]  pbuf_rd_data_i,
    output logic [DDR_W-1:0]   ddr_data_o,
    output logic               ddr_valid_o,
    input  logic               ddr_ready_i
);
    if (WPB < 1 || DDR_W % W != 0 || (WPB & (WPB - 1)) != 0) begin : g_bad_wpb
        $error("pbuf2ddr: DDR_W/(DATA_W*BATCH) must be a power of two >= 1");
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       bank_q, bank_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             done_q, done_d;
    logic [2:0]       cred_q;
    logic             rd_v_q, rd_last_q;
    logic [1:0]       rd_bank_q;
    logic [IW-1:0]    rd_idx_q;
    logic [DDR_W-1:0] pack_q;
    logic [DDR_W-1:0] mem [4];
    logic [1:0]       wp_q, rp_q;
    logic [2:0]       cnt_q;

    logic [IW-1:0]    idx;
    logic             new_beat, last_word, beat_end, issue, hs, push, more;
    logic [1:0]       nxt_bank, first;
    logic [W-1:0]     word;
    logic [DDR_W-1:0] cur;

    // A beat claims a credit when its first word is read and returns it on handshake,
    // so packed-but-unsent beats always have a FIFO slot waiting for them.
    always_comb begin
        idx       = IW'(addr_q & AW'(WPB - 1));
        new_beat  = idx == '0;
        last_word = PW'(addr_q) == pix_q - PW'(1);
        beat_end  = idx == IW'(WPB - 1) || last_word;
        issue     = state_q == READ && (!new_beat || cred_q < 3'd4);
        hs        = ddr_valid_o && ddr_ready_i;
        push      = rd_v_q && rd_last_q;
    end

    always_comb begin
        nxt_bank = bank_q;
        more     = 1'b0;
        first    = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            if (mask_q[b] && 2'(b) > bank_q) begin
                nxt_bank = 2'(b);
                more     = 1'b1;
            end
            if (bank_mask_i[b]) first = 2'(b);
        end
    end

    always_comb begin
        word = pbuf_rd_data_i[rd_bank_q];
`ifdef PBUF2DDR_RELU_EN
        for (int l = 0; l < BATCH; l++)
            if (word[l*DATA_W + DATA_W - 1]) word[l*DATA_W +: DATA_W] = '0;
`endif
        cur = (rd_idx_q == '0 ? '0 : pack_q) | (DDR_W'(word) << (W * int'(rd_idx_q)));
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (pix_num_i == '0 || bank_mask_i == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = READ;
                    pix_d   = pix_num_i;
                    mask_d  = bank_mask_i;
                    bank_d  = first;
                    addr_d  = '0;
                end
            end
            READ: if (issue) begin
                if (!last_word) begin
                    addr_d = addr_q + AW'(1);
                end else if (more) begin
                    bank_d = nxt_bank;
                    addr_d = '0;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (hs && cred_q == 3'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            mask_q    <= '0;
            bank_q    <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            cred_q    <= '0;
            rd_v_q    <= 1'b0;
            rd_last_q <= 1'b0;
            rd_bank_q <= '0;
            rd_idx_q  <= '0;
            pack_q    <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            mask_q    <= mask_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            cred_q    <= cred_q + 3'(issue && new_beat) - 3'(hs);
            rd_v_q    <= issue;
            rd_last_q <= beat_end;
            rd_bank_q <= bank_q;
            rd_idx_q  <= idx;
            pack_q    <= rd_v_q ? cur : pack_q;
            wp_q      <= wp_q + 2'(push);
            rp_q      <= rp_q + 2'(hs);
            cnt_q     <= cnt_q + 3'(push) - 3'(hs);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wp_q] <= cur;
    end

    assign busy_o         = state_q != IDLE;
    assign done_o         = done_q;
    assign ddr_valid_o    = cnt_q != '0;
    assign ddr_data_o     = ddr_valid_o ? mem[rp_q] : '0;
    assign pbuf_rd_en_o   = issue ? 4'b0001 << bank_q : 4'd0;
    assign pbuf_rd_addr_o = {4{addr_q}};
endmodule

// File: tb/tb_pbuf2ddr.sv
// tb_pbuf2ddr: table-driven check of pbuf2ddr at one and two words per beat,
// with a bank-memory model and a beat scoreboard built from the vector table.
module tb_pbuf2ddr;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
    logic [8:0] pix = '0;
    logic [3:0] mask = '0;
    logic [3:0] en1, en2, ens1, ens2;
    logic [3:0][7:0] ad1, ad2, ads1, ads2;
    logic [3:0][31:0] rd1 = '0, rd2 = '0;
    logic busy1, busy2, done1, done2, v1, v2;
    logic [31:0] dd1;
    logic [63:0] dd2;

    always #5 clk = ~clk;

    pbuf2ddr #(.DDR_W(32)) u_w1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pix_num_i(pix), .bank_mask_i(mask),
        .busy_o(busy1), .done_o(done1), .pbuf_rd_addr_o(ad1), .pbuf_rd_en_o(en1),
        .pbuf_rd_data_i(rd1), .ddr_data_o(dd1), .ddr_valid_o(v1), .ddr_ready_i(ready));
    pbuf2ddr #(.DDR_W(64)) u_w2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pix_num_i(pix), .bank_mask_i(mask),
        .busy_o(busy2), .done_o(done2), .pbuf_rd_addr_o(ad2), .pbuf_rd_en_o(en2),
        .pbuf_rd_data_i(rd2), .ddr_data_o(dd2), .ddr_valid_o(v2), .ddr_ready_i(ready));

    // Bank contents: lower lane is -3 on every fourth address, upper lane is sometimes negative.
    function automatic logic [31:0] pval(input int b, input int a);
        logic [15:0] hi, lo;
        hi = {1'(a[2] & a[0]), 3'(b), 12'(a)};
        lo = (a % 4 == 3) ? 16'hFFFD : {4'h7, 12'(a)};
        return {hi, lo};
    endfunction

    function automatic logic [31:0] eword(input int b, input int a);
        logic [31:0] w;
        w = pval(b, a);
`ifdef PBUF2DDR_RELU_EN
        if (w[31]) w[31:16] = '0;
        if (w[15]) w[15:0] = '0;
`endif
        return w;
    endfunction

    always @(negedge clk) begin
        ens1 = en1; ads1 = ad1;
        ens2 = en2; ads2 = ad2;
    end
    always @(posedge clk) for (int b = 0; b < 4; b++) rd1[b] <= ens1[b] ? pval(b, int'(ads1[b])) : 32'hDEADBEEF;
    always @(posedge clk) for (int b = 0; b < 4; b++) rd2[b] <= ens2[b] ? pval(b, int'(ads2[b])) : 32'hDEADBEEF;

    int n_chk = 0, n_fail = 0;

    function automatic bit chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    logic vv[2], bz[2], dn[2];
    logic [63:0] dd[2];
    logic [3:0] en[2];
    logic [3:0][7:0] ad[2];

    task automatic sample();
        vv[0] = v1; vv[1] = v2; bz[0] = busy1; bz[1] = busy2; dn[0] = done1; dn[1] = done2;
        dd[0] = {32'h0, dd1}; dd[1] = dd2; en[0] = en1; en[1] = en2; ad[0] = ad1; ad[1] = ad2;
    endtask

    task automatic chk_rst(input string tag);
        sample();
        for (int d = 0; d < 2; d++)
            void'(chk($sformatf("wpb%0d %s outputs", d + 1, tag), {bz[d], dn[d], vv[d], dd[d], en[d], ad[d]}, '0));
    endtask

    function automatic int nxt(input logic [3:0] m, input int b);
        for (int i = b + 1; i < 4; i++) if (m[i]) return i;
        return 4;
    endfunction

    typedef struct {
        int pix; logic [3:0] mask; bit rnd; bit restart;
        int b1; int b2; int done_c; int fv1; int fv2;
    } vec_t;

    logic [63:0] exp_b [2][1024];
    int nexp[2];

    task automatic run_vec(input int id, input vec_t t);
        int c, fv[2], nb[2], nrd[2], dcnt[2], dcyc[2], rb[2], ra[2], w, hb[2];
        bit bad_d[2], bad_r[2], bad_s[2], bad_o[2], pstall[2];
        logic [63:0] pdat[2], bt;
        hb[0] = t.b1; hb[1] = t.b2;
        for (int d = 0; d < 2; d++) begin
            w = d + 1; nexp[d] = 0;
            for (int b = 0; b < 4; b++) if (t.mask[b]) for (int a = 0; a < t.pix; a += w) begin
                bt = '0;
                for (int i = 0; i < w; i++) if (a + i < t.pix) bt |= 64'(eword(b, a + i)) << (32 * i);
                exp_b[d][nexp[d]] = bt; nexp[d]++;
            end
            fv[d] = 0; nb[d] = 0; nrd[d] = 0; dcnt[d] = 0; dcyc[d] = 0;
            rb[d] = nxt(t.mask, -1); ra[d] = 0;
            bad_d[d] = 0; bad_r[d] = 0; bad_s[d] = 0; bad_o[d] = 0; pstall[d] = 0; pdat[d] = '0;
        end
        @(negedge clk);
        pix = 9'(t.pix); mask = t.mask; start = 1'b1; ready = 1'b1;
        for (c = 1; c <= 20000; c++) begin
            @(negedge clk);
            start = t.restart && c == 4;
            if (start) begin pix = 9'd3; mask = 4'b0001; end
            ready = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            for (int d = 0; d < 2; d++) begin
                if (c == 1) void'(chk($sformatf("v%0d wpb%0d busy after start", id, d + 1), bz[d], hb[d] != 0));
                if (!bad_o[d]) bad_o[d] = !chk($sformatf("v%0d wpb%0d rd_en onehot", id, d + 1), $onehot0(en[d]), 1'b1);
                if (en[d] != 0) begin
                    nrd[d]++;
                    if (!bad_r[d]) begin
                        if (rb[d] > 3) bad_r[d] = !chk($sformatf("v%0d wpb%0d extra read", id, d + 1), en[d], 4'd0);
                        else bad_r[d] = !chk($sformatf("v%0d wpb%0d rd en/addr", id, d + 1),
                                             {en[d], ad[d][rb[d]]}, {4'b0001 << rb[d], 8'(ra[d])});
                    end
                    ra[d]++;
                    if (ra[d] == t.pix) begin ra[d] = 0; rb[d] = nxt(t.mask, rb[d]); end
                end
                if (pstall[d] && !bad_s[d])
                    bad_s[d] = !chk($sformatf("v%0d wpb%0d hold under stall", id, d + 1), {vv[d], dd[d]}, {1'b1, pdat[d]});
                if (vv[d] && fv[d] == 0) fv[d] = c;
                if (vv[d] && ready) begin
                    if (!bad_d[d] && nb[d] < nexp[d])
                        bad_d[d] = !chk($sformatf("v%0d wpb%0d beat%0d", id, d + 1, nb[d]), dd[d], exp_b[d][nb[d]]);
                    nb[d]++;
                end
                pstall[d] = vv[d] && !ready;
                pdat[d] = dd[d];
                if (dn[d]) begin
                    dcnt[d]++;
                    if (dcnt[d] == 1) dcyc[d] = c;
                    void'(chk($sformatf("v%0d wpb%0d busy with done", id, d + 1), bz[d], 1'b0));
                end
            end
            if (dcnt[0] > 0 && dcnt[1] > 0 && c >= dcyc[0] + 2 && c >= dcyc[1] + 2) break;
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            void'(chk($sformatf("v%0d wpb%0d done pulses", id, d + 1), dcnt[d], 1));
            void'(chk($sformatf("v%0d wpb%0d beats", id, d + 1), nb[d], hb[d]));
            void'(chk($sformatf("v%0d wpb%0d reads", id, d + 1), nrd[d], t.pix * $countones(t.mask)));
            if (t.done_c >= 0) begin
                void'(chk($sformatf("v%0d wpb%0d done cycle", id, d + 1), dcyc[d], t.done_c));
                void'(chk($sformatf("v%0d wpb%0d first valid cycle", id, d + 1), fv[d], d ? t.fv2 : t.fv1));
            end
        end
    endtask

    vec_t v[7];

    initial begin
        v[0] = '{8,   4'b0001, 1'b0, 1'b0, 8,    4,   11, 3, 4};
        v[1] = '{5,   4'b1010, 1'b0, 1'b0, 10,   6,   13, 3, 4};
        v[2] = '{0,   4'b1111, 1'b0, 1'b0, 0,    0,   1,  0, 0};
        v[3] = '{3,   4'b0000, 1'b0, 1'b0, 0,    0,   1,  0, 0};
        v[4] = '{1,   4'b1000, 1'b0, 1'b0, 1,    1,   4,  3, 3};
        v[5] = '{7,   4'b0101, 1'b0, 1'b1, 14,   8,   17, 3, 4};
        v[6] = '{256, 4'b1111, 1'b1, 1'b0, 1024, 512, -1, 0, 0};

        repeat (3) @(negedge clk);
        chk_rst("in reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_rst("after reset");

        for (int i = 0; i < 7; i++) run_vec(i, v[i]);

        // Reset in the middle of a backpressured stream, then a clean transfer.
        @(negedge clk);
        pix = 9'd20; mask = 4'b1111; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        sample();
        for (int d = 0; d < 2; d++) void'(chk($sformatf("wpb%0d stalled valid", d + 1), {vv[d], bz[d]}, 2'b11));
        rst_n = 1'b0;
        #1;
        chk_rst("async reset");
        repeat (2) begin
            @(negedge clk);
            chk_rst("reset hold");
        end
        rst_n = 1'b1;
        run_vec(7, v[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
